// File: rtl/ethernet_pkg.sv
// ethernet_pkg
//   Shared definitions for the Ethernet transmit pad/FCS path: the CRC-32
//   constants, the frame-size constants and the transmit state enum.
//   No ports. Imported by ethernet_crc32_step and ethernet_tx_pad_fcs.
package ethernet_pkg;

  // Reflected IEEE 802.3 CRC-32 parameters
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_FINAL_XOR = 32'hFFFFFFFF;

  // Shortest frame body (before FCS) and FCS length, both in bytes
  localparam int MIN_FRAME_BYTES = 60;
  localparam int FCS_BYTES       = 4;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    PAD  = 2'd1,
    FCS  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/ethernet_crc32_step.sv
// ethernet_crc32_step
//   Combinational update of a reflected CRC-32 over up to data_width_p/8
//   bytes. Lane 0 is processed first; only lanes with keep set take part.
//   Ports:
//     crc      - running CRC before this beat
//     data     - beat data, lane 0 in bits [7:0]
//     keep     - per-lane byte enable (low-contiguous)
//     crc_next - running CRC after this beat
module ethernet_crc32_step
  import ethernet_pkg::*;
#(
  parameter int data_width_p = 64
) (
  input  logic [31:0]               crc,
  input  logic [data_width_p-1:0]   data,
  input  logic [data_width_p/8-1:0] keep,
  output logic [31:0]               crc_next
);

  logic [31:0] c;

  // Bitwise LFSR unrolled over every lane; synthesis flattens it to XOR trees
  always_comb begin
    c = crc;
    for (int b = 0; b < data_width_p / 8; b++) begin
      if (keep[b]) begin
        c = c ^ {24'h000000, data[8*b +: 8]};
        for (int k = 0; k < 8; k++) begin
          c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
      end
    end
    crc_next = c;
  end

endmodule

// File: rtl/ethernet_tx_pad_fcs.sv
// ethernet_tx_pad_fcs
//   Sits between the packet sender and the MAC. Forwards each frame
//   unchanged, optionally pads short frames with zeros to 60 bytes, and
//   appends the 4-byte CRC-32 FCS (LSB byte first). The FCS is merged into
//   the free upper lanes of the final data beat; whatever does not fit goes
//   into one extra tail beat. A frame flagged with tuser on any input beat
//   gets tuser on its final output beat and a deliberately inverted FCS.
//   Optional feature: define ETHERNET_TX_MIN_PAD_EN to enable minimum-size
//   padding; without it the FCS always directly follows the last data byte.
//   Ports:
//     clk_i, reset_i     - clock, synchronous active-high reset
//     s_axis_*           - input frame stream (tdata/tkeep/tvalid/tlast/tuser, tready out)
//     m_axis_*           - registered output stream to the MAC (tready in)
//     frame_count_o      - frames completed on m_axis, wraps at 2^16
module ethernet_tx_pad_fcs
  import ethernet_pkg::*;
#(
  parameter int data_width_p = 64,
  parameter int eth_mtu_p    = 2048
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [data_width_p-1:0]   s_axis_tdata_i,
  input  logic [data_width_p/8-1:0] s_axis_tkeep_i,
  input  logic                      s_axis_tvalid_i,
  input  logic                      s_axis_tlast_i,
  input  logic                      s_axis_tuser_i,
  output logic                      s_axis_tready_o,
  output logic [data_width_p-1:0]   m_axis_tdata_o,
  output logic [data_width_p/8-1:0] m_axis_tkeep_o,
  output logic                      m_axis_tvalid_o,
  output logic                      m_axis_tlast_o,
  output logic                      m_axis_tuser_o,
  input  logic                      m_axis_tready_i,
  output logic [15:0]               frame_count_o
);

  localparam int kb    = data_width_p / 8;
  localparam int cnt_w = $clog2(eth_mtu_p + FCS_BYTES + 1);

`ifdef ETHERNET_TX_MIN_PAD_EN
  localparam bit pad_en = 1'b1;
`else
  localparam bit pad_en = 1'b0;
`endif

  tx_state_e               state, state_next;
  logic [31:0]             crc, crc_next;
  logic [cnt_w-1:0]        byte_cnt, byte_cnt_next;
  logic                    tuser_flag, tuser_flag_next;
  logic [31:0]             fcs_rest, fcs_rest_next;
  logic [2:0]              fcs_rem, fcs_rem_next;
  logic [data_width_p-1:0] tdata_next;
  logic [kb-1:0]           tkeep_next;
  logic                    tvalid_next, tlast_next, tuser_next;
  logic [data_width_p-1:0] step_data;
  logic [kb-1:0]           step_keep;
  logic [31:0]             step_crc;
  logic                    load_en, load_beat, last_data, flag_cur;
  logic [31:0]             fcs;
  int                      in_bytes, eff, total, free, room;

  // The output register may be (re)loaded when empty or being drained
  assign load_en         = ~m_axis_tvalid_o | m_axis_tready_i;
  assign s_axis_tready_o = ~reset_i & (state == PASS) & load_en;

  ethernet_crc32_step #(
    .data_width_p(data_width_p)
  ) u_crc_step (
    .crc     (crc),
    .data    (step_data),
    .keep    (step_keep),
    .crc_next(step_crc)
  );

  // Next-state and next-output logic. A "data beat" is either an accepted
  // input beat or a generated pad beat; eff is how many of its lanes hold
  // frame/pad bytes. When it is the last data beat the FCS is laid into the
  // lanes right after eff, spilling into the FCS state if it does not fit.
  always_comb begin
    state_next      = state;
    crc_next        = crc;
    byte_cnt_next   = byte_cnt;
    tuser_flag_next = tuser_flag;
    fcs_rest_next   = fcs_rest;
    fcs_rem_next    = fcs_rem;
    tdata_next      = m_axis_tdata_o;
    tkeep_next      = m_axis_tkeep_o;
    tvalid_next     = m_axis_tvalid_o & ~m_axis_tready_i;
    tlast_next      = m_axis_tlast_o;
    tuser_next      = m_axis_tuser_o;
    step_data       = '0;
    step_keep       = '0;
    load_beat       = 1'b0;
    last_data       = 1'b0;
    flag_cur        = tuser_flag;
    fcs             = '0;
    in_bytes        = 0;
    eff             = 0;
    total           = 0;
    free            = 0;
    room            = MIN_FRAME_BYTES - int'(byte_cnt);

    for (int i = 0; i < kb; i++) begin
      if (s_axis_tkeep_i[i]) in_bytes = in_bytes + 1;
    end

    case (state)
      PASS: begin
        if (s_axis_tvalid_i && s_axis_tready_o) begin
          load_beat = 1'b1;
          last_data = s_axis_tlast_i;
          flag_cur  = tuser_flag | s_axis_tuser_i;
          eff       = in_bytes;
          // A short frame's last beat is widened with zero lanes towards 60
          if (pad_en && s_axis_tlast_i && (in_bytes < room)) begin
            eff = (kb < room) ? kb : room;
          end
          for (int i = 0; i < kb; i++) begin
            if (i < in_bytes) step_data[8*i +: 8] = s_axis_tdata_i[8*i +: 8];
          end
        end
      end
      PAD: begin
        if (load_en) begin
          load_beat = 1'b1;
          last_data = 1'b1;
          eff       = (kb < room) ? kb : room;
        end
      end
      FCS: begin
        if (load_en) begin
          tvalid_next = 1'b1;
          tdata_next  = data_width_p'(fcs_rest);
          for (int i = 0; i < kb; i++) tkeep_next[i] = (i < int'(fcs_rem));
          tlast_next      = 1'b1;
          tuser_next      = tuser_flag;
          tuser_flag_next = 1'b0;
          state_next      = PASS;
        end
      end
      default: state_next = PASS;
    endcase

    for (int i = 0; i < kb; i++) step_keep[i] = (i < eff);

    if (load_beat) begin
      total       = int'(byte_cnt) + eff;
      tvalid_next = 1'b1;
      tdata_next  = step_data;
      tkeep_next  = '1;
      tlast_next  = 1'b0;
      tuser_next  = 1'b0;
      if (!last_data || (pad_en && (total < MIN_FRAME_BYTES))) begin
        crc_next        = step_crc;
        tuser_flag_next = flag_cur;
        byte_cnt_next   = (pad_en && (total > MIN_FRAME_BYTES)) ?
                          cnt_w'(MIN_FRAME_BYTES) : cnt_w'(total);
        state_next      = last_data ? PAD : PASS;
      end else begin
        // An errored frame carries the one's complement of the good FCS
        fcs  = step_crc ^ CRC_FINAL_XOR ^ {32{flag_cur}};
        free = kb - eff;
        for (int i = 0; i < kb; i++) begin
          if ((i >= eff) && (i < eff + FCS_BYTES)) tdata_next[8*i +: 8] = fcs[8*(i-eff) +: 8];
        end
        crc_next      = CRC_INIT;
        byte_cnt_next = '0;
        if (free >= FCS_BYTES) begin
          for (int i = 0; i < kb; i++) tkeep_next[i] = (i < eff + FCS_BYTES);
          tlast_next      = 1'b1;
          tuser_next      = flag_cur;
          tuser_flag_next = 1'b0;
          state_next      = PASS;
        end else begin
          fcs_rest_next   = fcs >> (8 * free);
          fcs_rem_next    = 3'(FCS_BYTES - free);
          tuser_flag_next = flag_cur;
          state_next      = FCS;
        end
      end
    end
  end

  // State, CRC, counters and the registered output stage
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state           <= PASS;
      crc             <= CRC_INIT;
      byte_cnt        <= '0;
      tuser_flag      <= 1'b0;
      fcs_rest        <= '0;
      fcs_rem         <= '0;
      m_axis_tdata_o  <= '0;
      m_axis_tkeep_o  <= '0;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tlast_o  <= 1'b0;
      m_axis_tuser_o  <= 1'b0;
      frame_count_o   <= '0;
    end else begin
      state           <= state_next;
      crc             <= crc_next;
      byte_cnt        <= byte_cnt_next;
      tuser_flag      <= tuser_flag_next;
      fcs_rest        <= fcs_rest_next;
      fcs_rem         <= fcs_rem_next;
      m_axis_tdata_o  <= tdata_next;
      m_axis_tkeep_o  <= tkeep_next;
      m_axis_tvalid_o <= tvalid_next;
      m_axis_tlast_o  <= tlast_next;
      m_axis_tuser_o  <= tuser_next;
      if (m_axis_tvalid_o && m_axis_tready_i && m_axis_tlast_o) begin
        frame_count_o <= frame_count_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ethernet_tx_pad_fcs.sv
// tb_ethernet_tx_pad_fcs
//   Drives random frames into a 64-bit and a 32-bit instance of
//   ethernet_tx_pad_fcs with random output back-pressure. Each frame's
//   expected output beats come from a byte-stream model (pad, CRC-32,
//   append FCS, chop into beats) and are queued; a monitor pops and
//   compares every accepted output beat and checks beats hold while stalled.
//   Follows ETHERNET_TX_MIN_PAD_EN the same way the design does.
module tb_ethernet_tx_pad_fcs;

  typedef logic [7:0] u8;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

`ifdef ETHERNET_TX_MIN_PAD_EN
  localparam bit pad_en = 1'b1;
`else
  localparam bit pad_en = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [63:0] s64_data;  logic [7:0] s64_keep;
  logic s64_valid, s64_last, s64_user, s64_ready;
  logic [63:0] m64_data;  logic [7:0] m64_keep;
  logic m64_valid, m64_last, m64_user, m64_ready;
  logic [15:0] count64;

  logic [31:0] s32_data;  logic [3:0] s32_keep;
  logic s32_valid, s32_last, s32_user, s32_ready;
  logic [31:0] m32_data;  logic [3:0] m32_keep;
  logic m32_valid, m32_last, m32_user, m32_ready;
  logic [15:0] count32;

  int    checks = 0;
  int    errors = 0;
  int    stall_pct = 30;
  int    frames64 = 0;
  int    frames32 = 0;
  int    beat_no[2];
  bit    stalled[2];
  beat_t held[2];
  beat_t exp64[$];
  beat_t exp32[$];
  beat_t a64, a32;

  ethernet_tx_pad_fcs #(.data_width_p(64), .eth_mtu_p(2048)) dut64 (
    .clk_i(clk), .reset_i(reset),
    .s_axis_tdata_i(s64_data), .s_axis_tkeep_i(s64_keep), .s_axis_tvalid_i(s64_valid),
    .s_axis_tlast_i(s64_last), .s_axis_tuser_i(s64_user), .s_axis_tready_o(s64_ready),
    .m_axis_tdata_o(m64_data), .m_axis_tkeep_o(m64_keep), .m_axis_tvalid_o(m64_valid),
    .m_axis_tlast_o(m64_last), .m_axis_tuser_o(m64_user), .m_axis_tready_i(m64_ready),
    .frame_count_o(count64)
  );

  ethernet_tx_pad_fcs #(.data_width_p(32), .eth_mtu_p(2048)) dut32 (
    .clk_i(clk), .reset_i(reset),
    .s_axis_tdata_i(s32_data), .s_axis_tkeep_i(s32_keep), .s_axis_tvalid_i(s32_valid),
    .s_axis_tlast_i(s32_last), .s_axis_tuser_i(s32_user), .s_axis_tready_o(s32_ready),
    .m_axis_tdata_o(m32_data), .m_axis_tkeep_o(m32_keep), .m_axis_tvalid_o(m32_valid),
    .m_axis_tlast_o(m32_last), .m_axis_tuser_o(m32_user), .m_axis_tready_i(m32_ready),
    .frame_count_o(count32)
  );

  // Plain reflected CRC-32 over a byte list, returning the raw register
  function automatic logic [31:0] crc32(input u8 s[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (s[i]) begin
      c = c ^ {24'h0, s[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Expected wire image of one frame: body, optional zero pad to 60, FCS
  task automatic modelFrame(input int which, input u8 fr[$], input bit err);
    u8 s[$];
    logic [31:0] fcs;
    beat_t b;
    int kb;
    kb = (which == 0) ? 8 : 4;
    s = fr;
    if (pad_en) while (s.size() < 60) s.push_back(8'h00);
    fcs = crc32(s) ^ 32'hFFFFFFFF;
    if (err) fcs = ~fcs;
    for (int k = 0; k < 4; k++) s.push_back(fcs[8*k +: 8]);
    for (int i = 0; i < s.size(); i += kb) begin
      b = '0;
      for (int j = 0; j < kb && i + j < s.size(); j++) begin
        b.data[8*j +: 8] = s[i+j];
        b.keep[j] = 1'b1;
      end
      b.last = (i + kb >= s.size());
      b.user = b.last & err;
      if (which == 0) exp64.push_back(b);
      else exp32.push_back(b);
    end
  endtask

  task automatic drive(input int which, input bit v, input logic [63:0] d, input logic [7:0] k,
                       input bit l, input bit u);
    if (which == 0) begin
      s64_valid = v; s64_data = d; s64_keep = k; s64_last = l; s64_user = u;
    end else begin
      s32_valid = v; s32_data = d[31:0]; s32_keep = k[3:0]; s32_last = l; s32_user = u;
    end
  endtask

  // Sends one frame; user_beat (or -1) marks which input beat carries tuser
  task automatic applyStimulus(input int which, input u8 fr[$], input int user_beat,
                               input bit push_model);
    int kb, nbeats, waited;
    bit acc;
    logic [63:0] d;
    logic [7:0] k;
    kb = (which == 0) ? 8 : 4;
    nbeats = (fr.size() + kb - 1) / kb;
    if (push_model) modelFrame(which, fr, (user_beat >= 0) && (user_beat < nbeats));
    for (int bi = 0; bi < nbeats; bi++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(which, 1'b0, '0, '0, 1'b0, 1'b0);
        @(posedge clk); #1;
      end
      d = '0; k = '0;
      for (int j = 0; j < kb && bi * kb + j < fr.size(); j++) begin
        d[8*j +: 8] = fr[bi*kb + j];
        k[j] = 1'b1;
      end
      drive(which, 1'b1, d, k, bi == nbeats - 1, bi == user_beat);
      acc = 1'b0;
      waited = 0;
      while (!acc) begin
        @(negedge clk); #1;
        acc = (which == 0) ? s64_ready : s32_ready;
        @(posedge clk); #1;
        waited++;
        if (!acc && waited > 1000) begin
          errors++; checks++;
          $display("[TB] FAIL s_tready_timeout dut%0d got no tready in %0d cycles want tready", which, waited);
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $fatal(1, "[TB] input stalled");
        end
      end
    end
    drive(which, 1'b0, '0, '0, 1'b0, 1'b0);
    if (which == 0) frames64++;
    else frames32++;
  endtask

  task automatic randomFrame(input int which, input int len, input int user_beat);
    u8 fr[$];
    for (int i = 0; i < len; i++) fr.push_back(u8'($urandom));
    applyStimulus(which, fr, user_beat, 1'b1);
  endtask

  task automatic checkScalar(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, act, want);
    end
  endtask

  // Compares an accepted beat with the head of the scoreboard and checks
  // that a stalled beat was held unchanged
  task automatic checkOutput(input int which, input beat_t act, input logic valid, input logic ready);
    beat_t exp;
    logic [63:0] mask;
    if (stalled[which]) begin
      checks++;
      if (!valid || act != held[which]) begin
        errors++;
        $display("[TB] FAIL stall_hold dut%0d got valid=%b beat=%h want valid=1 beat=%h",
                 which, valid, act, held[which]);
      end
    end
    if (valid && ready) begin
      checks++;
      if ((which == 0 && exp64.size() == 0) || (which == 1 && exp32.size() == 0)) begin
        errors++;
        $display("[TB] FAIL unexpected_beat dut%0d got beat=%h want none", which, act);
      end else begin
        if (which == 0) exp = exp64.pop_front();
        else exp = exp32.pop_front();
        for (int j = 0; j < 8; j++) mask[8*j +: 8] = {8{exp.keep[j]}};
        if (act.keep != exp.keep || (act.data & mask) != exp.data ||
            act.last != exp.last || act.user != exp.user) begin
          errors++;
          $display("[TB] FAIL beat%0d dut%0d got data=%h keep=%h last=%b user=%b want data=%h keep=%h last=%b user=%b",
                   beat_no[which], which, act.data & mask, act.keep, act.last, act.user,
                   exp.data, exp.keep, exp.last, exp.user);
        end
      end
      beat_no[which]++;
    end
    stalled[which] = valid && !ready;
    held[which] = act;
  endtask

  // Monitor: pick this cycle's back-pressure, then inspect both outputs
  always @(negedge clk) begin
    m64_ready = ($urandom_range(0, 99) >= stall_pct);
    m32_ready = ($urandom_range(0, 99) >= stall_pct);
    if (!reset) begin
      a64 = {m64_data, m64_keep, m64_last, m64_user};
      a32 = {32'h0, m32_data, 4'h0, m32_keep, m32_last, m32_user};
      checkOutput(0, a64, m64_valid, m64_ready);
      checkOutput(1, a32, m32_valid, m32_ready);
    end
  end

  task automatic drain(input int which);
    int n = 0;
    while (((which == 0) ? exp64.size() : exp32.size()) != 0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) begin
      errors++; checks++;
      $display("[TB] FAIL drain_timeout dut%0d got %0d beats pending want 0", which,
               (which == 0) ? exp64.size() : exp32.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    u8 fr[$];
    beat_t g;
    reset = 1'b1;
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    m64_ready = 1'b1;
    m32_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkScalar("reset_tvalid64", int'(m64_valid), 0);
    checkScalar("reset_tdata64", int'(m64_data != 64'h0), 0);
    checkScalar("reset_tkeep64", int'(m64_keep), 0);
    checkScalar("reset_tlast_tuser64", int'({m64_last, m64_user}), 0);
    checkScalar("reset_count64", int'(count64), 0);
    checkScalar("reset_tready64", int'(s64_ready), 0);
    checkScalar("reset_tvalid32", int'(m32_valid), 0);
    checkScalar("reset_tready32", int'(s32_ready), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkScalar("idle_tready64", int'(s64_ready), 1);

    // "123456789" on the 64-bit instance
    for (int i = 0; i < 9; i++) fr.push_back(u8'(8'h31 + i));
    if (!pad_en) begin
      g = '{data: 64'h3837363534333231, keep: 8'hFF, last: 1'b0, user: 1'b0};
      exp64.push_back(g);
      g = '{data: 64'h000000CBF4392639, keep: 8'h1F, last: 1'b1, user: 1'b0};
      exp64.push_back(g);
      applyStimulus(0, fr, -1, 1'b0);
    end else begin
      applyStimulus(0, fr, -1, 1'b1);
    end
    drain(0);
    checkScalar("golden_count64", int'(count64), 1);

    // 100-byte frame with tuser on its third beat
    randomFrame(0, 100, 2);
    for (int f = 0; f < 50; f++) begin
      int len;
      len = $urandom_range(1, 150);
      randomFrame(0, len, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (len + 7) / 8 - 1)) : -1);
    end
    drain(0);
    checkScalar("count64", int'(count64), frames64);

    // 32-bit instance: 64-byte frame, 62-byte frame, then random traffic
    randomFrame(1, 64, -1);
    drain(1);
    checkScalar("count32_first", int'(count32), 1);
    randomFrame(1, 62, -1);
    for (int f = 0; f < 48; f++) begin
      int len;
      len = $urandom_range(1, 150);
      randomFrame(1, len, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (len + 3) / 4 - 1)) : -1);
    end
    drain(1);
    checkScalar("count32", int'(count32), frames32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ethernet_tx_pad_fcs.md
ETHERNET_TX_PAD_FCS -- requirements
Module: ethernet_tx_pad_fcs

Interface
REQ-001 SHALL have parameter data_width_p, default 64: AXIS data width in bits; only 32 and 64 are legal.
REQ-002 SHALL have parameter eth_mtu_p, default 2048: maximum input frame size in bytes; sizes the byte counter.
REQ-003 SHALL have port clk_i, input, 1: the single clock.
REQ-004 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports s_axis_tdata_i / tkeep_i / tvalid_i / tlast_i / tuser_i (inputs, widths data_width_p / data_width_p/8 / 1 / 1 / 1) and s_axis_tready_o (output, 1): frame stream from the packet sender.
REQ-006 SHALL have ports m_axis_tdata_o / tkeep_o / tvalid_o / tlast_o / tuser_o (outputs, same widths) and m_axis_tready_i (input, 1): frame stream to the MAC.
REQ-007 SHALL have port frame_count_o, output, 16: count of frames completed on m_axis, wrapping at 2^16.

Function
REQ-008 SHALL require input tkeep all-ones on non-last beats and low-contiguous, non-zero on the last beat.
REQ-009 SHALL forward frame bytes unchanged, in order, lane 0 = first byte, so that m_axis carries the same byte stream followed by padding (REQ-013) and a 4-byte FCS.
REQ-010 SHALL compute the FCS as CRC-32 IEEE 802.3: reflected poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF, covering data and pad bytes, and SHALL transmit it LSB byte first.
REQ-011 SHALL use a registered output stage: an accepted input beat appears on m_axis no earlier than the next cycle; s_axis_tready_o = state==PASS & (~m_axis_tvalid_o | m_axis_tready_i).
REQ-012 SHALL implement states PASS, PAD and FCS: PASS->PAD when the last input beat is accepted and the byte count is below 60 (only with REQ-022); PASS/PAD->FCS when FCS bytes remain after the output beat just loaded; otherwise return to PASS; FCS->PASS when the tail beat is accepted.
REQ-013 SHALL, in PAD, emit zero bytes (tkeep all-ones) until 60 bytes have been sent, placing the FCS in the lanes starting at byte 60.
REQ-014 SHALL merge the FCS into the free upper lanes of the final data/pad beat; any remaining FCS bytes go into one extra beat in state FCS, in lanes starting at 0.
REQ-015 SHALL assert m_axis_tlast_o only on the beat carrying the last FCS byte.
REQ-016 SHALL assert m_axis_tuser_o on that final beat if any input beat of the frame had tuser set, and SHALL then invert the transmitted FCS.
REQ-017 SHALL hold m_axis data and control stable while m_axis_tvalid_o=1 and m_axis_tready_i=0.
REQ-018 SHALL saturate the byte counter at 60 when REQ-022 is active; otherwise it is log2-sized to eth_mtu_p+4 with no wrap.
REQ-019 SHALL increment frame_count_o on acceptance of an m_axis tlast beat.

Reset
REQ-020 SHALL, on reset_i=1, set state=PASS, CRC=0xFFFFFFFF, byte count=0, tuser flag=0, m_axis_tvalid_o=0, tlast/tuser/tkeep/tdata outputs=0 and frame_count_o=0.
REQ-021 SHALL abandon any frame in flight on reset without emitting a tail; s_axis_tready_o=0 while reset_i=1.

Configuration
REQ-022 SHALL pad short frames to 60 bytes (REQ-013) only when ETHERNET_TX_MIN_PAD_EN is defined; when it is undefined, PAD is unreachable and the FCS directly follows the last input byte regardless of length.

Structure
REQ-023 SHALL place the CRC constants (poly, init, final XOR), the minimum frame size of 60, the FCS length of 4 and the state enum typedef in the shared package ethernet_pkg.
REQ-024 SHALL instantiate one sub-module, ethernet_crc32_step: combinational update of a 32-bit CRC over up to data_width_p/8 bytes masked by tkeep.

Verification
REQ-025 SHALL verify, with the macro undefined, W=64: a 9-byte frame "123456789" produces 2 beats: tkeep 0xFF, then 0x1F with FCS bytes 26 39 F4 CB in lanes 1-4, tlast on beat 2.
REQ-026 SHALL verify, with the macro defined, W=64: a 9-byte frame produces 8 beats, 64 bytes total, with zeros in bytes 9-59, FCS in lanes 4-7 of beat 8, tkeep 0xFF on all beats, and FCS matching the golden model.
REQ-027 SHALL verify, W=32: a 64-byte frame produces 17 beats, the last with tkeep 0xF carrying the full FCS; frame_count_o=1.
REQ-028 SHALL verify, W=32: a 62-byte frame (last tkeep 0x3) produces a final data beat with tkeep 0xF (2 FCS bytes), then a tail beat with tkeep 0x3.
REQ-029 SHALL verify that random m_axis_tready_i stalls over 100 frames produce byte-identical output and that no beat changes while stalled.
REQ-030 SHALL verify that tuser=1 on beat 3 of a 100-byte frame yields m_axis_tuser_o=1 on the final beat only and an inverted FCS.
